dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Sequencer and arbiter in front of the pipeline's data memory. Shares the single DM port between the M-stage load/store unit (CPU) and a word-wide DMA requester. Generates byte enables, write-data lane replication and load extraction/extension from a 2-bit access width. Stalls the pipeline while a CPU access is outstanding.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request; held stable until cpu_done
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wd  in  32  store data (low lanes significant for half/byte)
- cpu_width  in  2  2'b00 word, 2'b01 half, 2'b10 byte (2'b11 treated as word)
- cpu_signed  in  1  1 = sign-extend half/byte loads, 0 = zero-extend
- cpu_stall  out  1  combinational: cpu_req & ~cpu_done & ~reset
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle misalignment pulse, coincident with cpu_done
- cpu_rdata  out  32  extracted/extended load data, valid while cpu_done
- dma_req  in  1  DMA word request; held until dma_rvalid
- dma_we  in  1  DMA write
- dma_addr  in  32  word address (bits [1:0] ignored)
- dma_wd  in  32  DMA write data
- dma_gnt  out  1  one-cycle pulse in the access cycle of a DMA transaction
- dma_rvalid  out  1  one-cycle completion pulse
- dma_rdata  out  32  raw word read, valid while dma_rvalid
- mem_we  out  1  DM write strobe
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_byteen  out  4  lane write enables
- mem_wd  out  32  lane-replicated write data
- mem_rd  in  32  DM combinational read data

## Operation
- FSM: IDLE, ACC, RESP. Reset -> IDLE.
- IDLE: if any request, latch winner's request fields into internal registers, record owner, -> ACC; else stay.
- Arbitration: CPU wins when only CPU requests or under fixed priority (see Configuration); DMA wins when alone.
- ACC: drive mem_* from latched fields; capture mem_rd; -> RESP. dma_gnt=1 if owner is DMA.
- RESP: pulse cpu_done (+cpu_err) or dma_rvalid with registered data; -> IDLE. Requests are never sampled in RESP (prevents double-issue of a held request).
- Byte enables (store): word 4'b1111; half addr[1]=0 -> 4'b0011, 1 -> 4'b1100; byte 4'b0001 << addr[1:0]. DMA always 4'b1111.
- Write data: word as-is; half {2{wd[15:0]}}; byte {4{wd[7:0]}}.
- Load extraction: half selects mem_rd[15:0] or [31:16] by addr[1]; byte selects lane addr[1:0]; upper bits zero or sign of selected MSB per cpu_signed.
- Misalignment: word with addr[1:0]!=0, half with addr[0]!=0 -> mem_we=0, mem_byteen=0 in ACC, cpu_rdata=0, cpu_err=1 in RESP.
- Outside ACC: mem_we=0, mem_byteen=0, mem_addr=0, mem_wd=0.

## Timing
- Request seen high at edge ending cycle N -> ACC in N+1 (write commits at edge ending N+1) -> RESP in N+2 (done/rvalid high) -> IDLE in N+3.
- Latency 2 cycles request-to-completion; one transaction per 3 cycles.
- Reset values: all registered outputs 0; cpu_stall 0; mem_we forced 0 whenever reset=1, including reset during ACC (write aborted).
- Reset in RESP suppresses the pulse; requester re-issues.
- Simultaneous cpu_req/dma_req in IDLE resolved by Configuration rule; loser waits, its request still held.
- Request deasserted before sampling: ignored; deasserted after latch: transaction completes anyway.

## Configuration
- DM_ARB_RR_EN defined: round-robin on simultaneous requests — grant goes to the requester not granted last (last_owner register, reset to DMA so CPU wins first tie).
- Undefined: fixed priority, CPU always wins ties; DMA can starve under back-to-back CPU traffic.

## Test plan
- CPU sw addr 0x0000_0010, wd 0x1234_5678 -> ACC: mem_we=1, mem_byteen 4'b1111, mem_addr 0x10; RESP: cpu_done=1; cpu_stall high exactly 2 cycles.
- CPU sb addr 0x13 wd 0x0000_00AB -> mem_byteen 4'b1000, mem_wd 0xABAB_ABAB; then lb signed from 0x13 -> cpu_rdata 0xFFFF_FFAB; lbu -> 0x0000_00AB.
- CPU lh signed addr 0x12 with mem_rd 0x8001_7FFF -> cpu_rdata 0xFFFF_8001; addr 0x10 -> 0x0000_7FFF.
- CPU sw addr 0x22 -> no write (mem_we=0), cpu_err=1 with cpu_done, cpu_rdata 0.
- cpu_req and dma_req both held for 12 cycles -> with DM_ARB_RR_EN grants alternate CPU, DMA, CPU, DMA; without, four CPU grants, dma_gnt never pulses.
- Reset asserted in ACC of DMA write 0xDEAD_BEEF -> mem_we=0 that cycle, no dma_rvalid, FSM IDLE next cycle.

Source files
------------

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Purpose  : Shares the single data-memory port between the M-stage
//            load/store unit (CPU) and a word-wide DMA requester. Each
//            transaction is IDLE -> ACC -> RESP. Generates byte enables,
//            write-lane replication and load extraction/extension, and
//            stalls the pipeline while a CPU access is outstanding.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            cpu_*  (in)         - CPU request, width, address, store data
//            cpu_stall/done/err/rdata (out) - CPU handshake and load data
//            dma_*  (in)         - DMA word request
//            dma_gnt/rvalid/rdata (out)     - DMA handshake and raw read data
//            mem_we/addr/byteen/wd (out), mem_rd (in) - data-memory port
// Config   : DM_ARB_RR_EN - when defined, simultaneous requests alternate
//            (round-robin); otherwise the CPU always wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_signed,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic       OWN_CPU = 1'b0;
  localparam logic       OWN_DMA = 1'b1;
  localparam logic [1:0] W_WORD  = 2'b00;
  localparam logic [1:0] W_HALF  = 2'b01;
  localparam logic [1:0] W_BYTE  = 2'b10;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [1:0]  width_q, width_d;
  logic        signed_q, signed_d;
  logic        err_q, err_d;
  logic [31:0] rd_q, rd_d;
`ifdef DM_ARB_RR_EN
  logic        last_owner_q, last_owner_d;
`endif

  logic        cpu_wins;
  logic        cpu_misalign;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_ext;

  // Arbitration: a lone requester always wins; only ties differ by build.
  always_comb begin
`ifdef DM_ARB_RR_EN
    cpu_wins = cpu_req & (~dma_req | (last_owner_q == OWN_DMA));
`else
    cpu_wins = cpu_req;
`endif
  end

  // Misalignment of the incoming CPU request; width 2'b11 behaves as word.
  always_comb begin
    unique case (cpu_width)
      W_HALF:  cpu_misalign = cpu_addr[0];
      W_BYTE:  cpu_misalign = 1'b0;
      default: cpu_misalign = (cpu_addr[1:0] != 2'b00);
    endcase
  end

  // Lane enables and replicated write data from the latched fields. DMA is
  // latched as a word access, so it naturally gets 4'b1111 and raw data.
  always_comb begin
    unique case (width_q)
      W_HALF: begin
        lane_be = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{wd_q[15:0]}};
      end
      W_BYTE: begin
        lane_be = 4'b0001 << addr_q[1:0];
        lane_wd = {4{wd_q[7:0]}};
      end
      default: begin
        lane_be = 4'b1111;
        lane_wd = wd_q;
      end
    endcase
  end

  // Load extraction and sign/zero extension.
  always_comb begin
    half_sel = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    unique case (addr_q[1:0])
      2'd0:    byte_sel = mem_rd[7:0];
      2'd1:    byte_sel = mem_rd[15:8];
      2'd2:    byte_sel = mem_rd[23:16];
      default: byte_sel = mem_rd[31:24];
    endcase
    unique case (width_q)
      W_HALF:  load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
      W_BYTE:  load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
      default: load_ext = mem_rd;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    width_d    = width_q;
    signed_d   = signed_q;
    err_d      = err_q;
    rd_d       = rd_q;
`ifdef DM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_byteen = 4'b0000;
    mem_wd     = 32'h0;
    dma_gnt    = 1'b0;
    cpu_done   = 1'b0;
    cpu_err    = 1'b0;
    cpu_rdata  = 32'h0;
    dma_rvalid = 1'b0;
    dma_rdata  = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req | dma_req) begin
          state_d = ST_ACC;
          if (cpu_wins) begin
            owner_d  = OWN_CPU;
            we_d     = cpu_we;
            addr_d   = cpu_addr;
            wd_d     = cpu_wd;
            width_d  = cpu_width;
            signed_d = cpu_signed;
            err_d    = cpu_misalign;
          end else begin
            // Low address bits are carried along but never matter: the
            // access is a word, mem_addr masks them and no misalign check.
            owner_d  = OWN_DMA;
            we_d     = dma_we;
            addr_d   = dma_addr;
            wd_d     = dma_wd;
            width_d  = W_WORD;
            signed_d = 1'b0;
            err_d    = 1'b0;
          end
`ifdef DM_ARB_RR_EN
          last_owner_d = cpu_wins ? OWN_CPU : OWN_DMA;
`endif
        end
      end

      ST_ACC: begin
        state_d = ST_RESP;
        if (!reset) begin
          // Reset during ACC aborts the write in the same cycle.
          mem_we     = we_q & ~err_q;
          mem_byteen = (we_q & ~err_q) ? lane_be : 4'b0000;
          mem_addr   = {addr_q[31:2], 2'b00};
          mem_wd     = lane_wd;
          dma_gnt    = (owner_q == OWN_DMA);
        end
        if (owner_q == OWN_DMA) begin
          rd_d = mem_rd;
        end else begin
          rd_d = (err_q | we_q) ? 32'h0 : load_ext;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        // Pulses are suppressed if reset lands in RESP; requester re-issues.
        if (!reset) begin
          if (owner_q == OWN_CPU) begin
            cpu_done  = 1'b1;
            cpu_err   = err_q;
            cpu_rdata = rd_q;
          end else begin
            dma_rvalid = 1'b1;
            dma_rdata  = rd_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_done & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_CPU;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wd_q     <= 32'h0;
      width_q  <= W_WORD;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 32'h0;
`ifdef DM_ARB_RR_EN
      // DMA as "last owner" lets the CPU win the first tie after reset.
      last_owner_q <= OWN_DMA;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      width_q  <= width_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
`ifdef DM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arbiter
// Purpose  : Directed self-checking bench for dm_port_arbiter. A small
//            byte-lane memory model sits on the DM port; expected responses
//            are queued when a request is driven and compared on completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_signed;
  logic [31:0] cpu_addr, cpu_wd;
  logic [1:0]  cpu_width;
  logic        cpu_stall, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wd;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [3:0]  mem_byteen;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;
  exp_t cpu_q[$];
  exp_t dma_q[$];

  // Observations from the ACC cycle of the last transaction.
  logic        acc_we, acc_gnt;
  logic [3:0]  acc_be;
  logic [31:0] acc_addr, acc_wd;
  int          stall_cnt;

  // Memory model.
  logic        mem_clr;
  logic [31:0] mem [0:63];
  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_width(cpu_width), .cpu_signed(cpu_signed),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] width, input logic sgn,
                        input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd);
    exp_t e;
    int   cyc;
    int   done_cyc;
    logic got;
    e.rdata = exp_rd; e.err = exp_err; e.chk = chk_rd;
    cpu_q.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wd = wd;
    cpu_width = width; cpu_signed = sgn;
    #1;
    cyc = 0; got = 1'b0; stall_cnt = 0; done_cyc = -1;
    while (!got && cyc < 8) begin
      if (cpu_stall) stall_cnt++;
      if (cyc == 1) begin
        acc_we = mem_we; acc_be = mem_byteen; acc_addr = mem_addr;
        acc_wd = mem_wd; acc_gnt = dma_gnt;
      end
      if (cpu_done) begin
        got = 1'b1; done_cyc = cyc;
        e = cpu_q.pop_front();
        check("cpu_err", {31'h0, cpu_err}, {31'h0, e.err});
        if (e.chk) check("cpu_rdata", cpu_rdata, e.rdata);
        cpu_req = 1'b0;
      end else begin
        @(negedge clk); #1; cyc++;
      end
    end
    check("cpu_done_seen", {31'h0, got}, 32'h1);
    if (!got) begin
      cpu_req = 1'b0;
      void'(cpu_q.pop_front());
    end else begin
      check("cpu_latency", done_cyc, 2);
    end
  endtask

  task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic chk_rd);
    exp_t e;
    int   cyc;
    logic got;
    e.rdata = exp_rd; e.err = 1'b0; e.chk = chk_rd;
    dma_q.push_back(e);
    @(negedge clk);
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wd = wd;
    #1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 8) begin
      if (cyc == 1) begin
        acc_we = mem_we; acc_be = mem_byteen; acc_addr = mem_addr;
        acc_wd = mem_wd; acc_gnt = dma_gnt;
      end
      if (dma_rvalid) begin
        got = 1'b1;
        e = dma_q.pop_front();
        if (e.chk) check("dma_rdata", dma_rdata, e.rdata);
        check("dma_latency", cyc, 2);
        dma_req = 1'b0;
      end else begin
        @(negedge clk); #1; cyc++;
      end
    end
    check("dma_rvalid_seen", {31'h0, got}, 32'h1);
    if (!got) begin
      dma_req = 1'b0;
      void'(dma_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int gnts;
    int rv_cnt;

    reset = 1'b1; mem_clr = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wd = 32'h0;
    cpu_width = 2'b00; cpu_signed = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wd = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    // Reset state: stall masked even with a pending request.
    check("rst_cpu_stall", {31'h0, cpu_stall}, 32'h0);
    check("rst_cpu_done", {31'h0, cpu_done}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dma_rvalid", {31'h0, dma_rvalid}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_byteen", {28'h0, mem_byteen}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    cpu_req = 1'b0; reset = 1'b0; mem_clr = 1'b0;

    // sw 0x10
    cpu_op(1'b1, 32'h10, 32'h1234_5678, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    check("sw_we", {31'h0, acc_we}, 32'h1);
    check("sw_be", {28'h0, acc_be}, 32'hF);
    check("sw_addr", acc_addr, 32'h10);
    check("sw_wd", acc_wd, 32'h1234_5678);
    check("sw_stall_cycles", stall_cnt, 2);

    // sb 0x13
    cpu_op(1'b1, 32'h13, 32'h0000_00AB, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
    check("sb_be", {28'h0, acc_be}, 32'h8);
    check("sb_wd", acc_wd, 32'hABAB_ABAB);
    check("sb_addr", acc_addr, 32'h10);

    // lb / lbu 0x13 (word now 0xAB345678)
    cpu_op(1'b0, 32'h13, 32'h0, 2'b10, 1'b1, 32'hFFFF_FFAB, 1'b0, 1'b1);
    check("lb_no_write", {31'h0, acc_we}, 32'h0);
    cpu_op(1'b0, 32'h13, 32'h0, 2'b10, 1'b0, 32'h0000_00AB, 1'b0, 1'b1);
    cpu_op(1'b0, 32'h11, 32'h0, 2'b10, 1'b1, 32'h0000_0056, 1'b0, 1'b1);

    // Halfword loads from 0x8001_7FFF
    cpu_op(1'b1, 32'h10, 32'h8001_7FFF, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    cpu_op(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1);
    cpu_op(1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 32'h0000_7FFF, 1'b0, 1'b1);
    cpu_op(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 32'h0000_8001, 1'b0, 1'b1);

    // sh 0x12: upper lanes, replicated data
    cpu_op(1'b1, 32'h12, 32'h0000_BEEF, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
    check("sh_be", {28'h0, acc_be}, 32'hC);
    check("sh_wd", acc_wd, 32'hBEEF_BEEF);

    // Misaligned sw and lh
    cpu_op(1'b1, 32'h22, 32'h5555_5555, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1);
    check("mis_we", {31'h0, acc_we}, 32'h0);
    check("mis_be", {28'h0, acc_be}, 32'h0);
    check("mis_mem", mem[8], 32'h0);
    cpu_op(1'b0, 32'h11, 32'h0, 2'b01, 1'b1, 32'h0, 1'b1, 1'b1);

    // DMA write (low address bits ignored) then read back
    dma_op(1'b1, 32'h27, 32'hCAFE_F00D, 32'h0, 1'b0);
    check("dma_gnt", {31'h0, acc_gnt}, 32'h1);
    check("dma_addr", acc_addr, 32'h24);
    check("dma_be", {28'h0, acc_be}, 32'hF);
    dma_op(1'b0, 32'h24, 32'h0, 32'hCAFE_F00D, 1'b1);

    // Simultaneous requests held for 12 cycles; last grant was DMA.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_width = 2'b00; cpu_signed = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    #1;
    gnts = 0;
    for (int i = 0; i < 12; i++) begin
      if (cpu_done) order.push_back(0);
      if (dma_rvalid) order.push_back(1);
      if (dma_gnt) gnts++;
      if (i == 11) begin
        cpu_req = 1'b0; dma_req = 1'b0;
      end else begin
        @(negedge clk); #1;
      end
    end
    check("tie_completions", order.size(), 4);
    for (int k = 0; k < order.size() && k < 4; k++) begin
`ifdef DM_ARB_RR_EN
      check($sformatf("tie_owner_%0d", k), order[k], k % 2);
`else
      check($sformatf("tie_owner_%0d", k), order[k], 0);
`endif
    end
`ifdef DM_ARB_RR_EN
    check("tie_dma_gnts", gnts, 2);
`else
    check("tie_dma_gnts", gnts, 0);
`endif

    // Reset during ACC of a DMA write aborts it.
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_wd = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    check("rst_acc_gnt", {31'h0, dma_gnt}, 32'h1);
    check("rst_acc_pre_we", {31'h0, mem_we}, 32'h1);
    reset = 1'b1; dma_req = 1'b0;
    #1;
    check("rst_acc_mem_we", {31'h0, mem_we}, 32'h0);
    rv_cnt = 0;
    @(negedge clk); #1;
    if (dma_rvalid) rv_cnt++;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (dma_rvalid) rv_cnt++;
    end
    check("rst_acc_no_rvalid", rv_cnt, 0);
    check("rst_acc_no_write", mem[12], 32'h0);

    // Normal operation after the aborted transaction.
    cpu_op(1'b0, 32'h30, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1);
    cpu_op(1'b0, 32'h24, 32'h0, 2'b11, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
